// File: rtl/spi_flash_reader.sv
// SPI master that streams bytes out of a serial configuration flash with READ (0x03).
// Chip-select stays low between sequential requests so a long image pays the command cost once.
module spi_flash_reader #(
    parameter int CLK_DIV   = 2,
    parameter int DESEL_CYC = 4
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        read,
    input  logic        rden,
    input  logic [23:0] addr,
    output logic [7:0]  dataout,
    output logic        data_valid,
    output logic        busy,
    output logic        flash_ncs,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int DW = $clog2(DESEL_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DESEL_MAX = DW'(DESEL_CYC - 1);
    localparam logic [7:0]    READ_CMD  = 8'h03;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DESEL} state_t;

    // Handshake: a request is the single cycle where read=1 and rden=1 while the FSM
    // sits in IDLE or HOLD; read in any other cycle is dropped, and rden=0 ends the stream.
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [23:0]   cur_addr_q, cur_addr_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          restart_q, restart_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          ncs_q, ncs_d;
    logic [7:0]    dout_q, dout_d;
    logic          dv_q, dv_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic          tick;

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cur_addr_q <= '0;
            dcnt_q     <= '0;
            restart_q  <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ncs_q      <= 1'b1;
            dout_q     <= 8'h00;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cur_addr_q <= cur_addr_d;
            dcnt_q     <= dcnt_d;
            restart_q  <= restart_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ncs_q      <= ncs_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cur_addr_d = cur_addr_q;
        dcnt_d     = dcnt_q;
        restart_d  = restart_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        dout_d     = dout_q;
        dv_d       = 1'b0;
        accept     = read && rden && (state_q == IDLE || state_q == HOLD);
        tick       = (cnt_q == CNT_MAX);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_addr_d = addr;
                    tx_d       = {READ_CMD, addr};
                    state_d    = CMD;
                    cnt_d      = '0;
                    bit_d      = '0;
                    sck_d      = 1'b0;
                    mosi_d     = READ_CMD[7];
                end
            end
            CMD, ADDR, DATA: begin
                if (!rden) begin
                    state_d   = DESEL;
                    dcnt_d    = '0;
                    restart_d = 1'b0;
                    cnt_d     = '0;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CW'(1);
                    if (tick) begin
                        sck_d = !sck_q;
                        if (!sck_q) begin
                            if (state_q == DATA) rx_d = {rx_q[6:0], flash_miso};
                        end else begin
                            // Falling SCK closes a bit: present the next MOSI bit while SCK is low.
                            bit_d  = bit_q + 5'd1;
                            tx_d   = {tx_q[30:0], 1'b0};
                            mosi_d = tx_q[30];
                            if (state_q == CMD && bit_q == 5'd7) begin
                                state_d = ADDR;
                                bit_d   = '0;
                            end else if (state_q == ADDR && bit_q == 5'd23) begin
                                state_d = DATA;
                                bit_d   = '0;
                                mosi_d  = 1'b0;
                            end else if (state_q == DATA) begin
                                mosi_d = 1'b0;
                                if (bit_q == 5'd7) begin
                                    state_d    = HOLD;
                                    bit_d      = '0;
                                    dout_d     = rx_q;
                                    dv_d       = 1'b1;
                                    cur_addr_d = cur_addr_q + 24'd1;
                                end
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (!rden) begin
                    state_d   = DESEL;
                    dcnt_d    = '0;
                    restart_d = 1'b0;
                end else if (accept) begin
                    if (addr == cur_addr_q) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        cur_addr_d = addr;
                        state_d    = DESEL;
                        dcnt_d     = '0;
                        restart_d  = 1'b1;
                    end
                end
            end
            DESEL: begin
                dcnt_d = dcnt_q + DW'(1);
                if (!rden) restart_d = 1'b0;
                if (dcnt_q == DESEL_MAX) begin
                    dcnt_d = '0;
                    if (restart_q && rden) begin
                        restart_d = 1'b0;
                        tx_d      = {READ_CMD, cur_addr_q};
                        state_d   = CMD;
                        cnt_d     = '0;
                        bit_d     = '0;
                        sck_d     = 1'b0;
                        mosi_d    = READ_CMD[7];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ncs_d  = !(state_d == CMD || state_d == ADDR || state_d == DATA || state_d == HOLD);
        busy_d = (state_d == CMD || state_d == ADDR || state_d == DATA || state_d == DESEL);
    end

    assign dataout    = dout_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;
    assign flash_ncs  = ncs_q;
    assign flash_sck  = sck_q;
    assign flash_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash plus a request-level model of
// latency, command traffic and returned bytes.
module tb_spi_flash_reader;

    localparam int CLK_DIV   = 2;
    localparam int DESEL_CYC = 4;
    localparam int B         = 2 * CLK_DIV;

    logic        clk28 = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic        rden = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  dataout;
    logic        data_valid;
    logic        busy;
    logic        flash_ncs;
    logic        flash_sck;
    logic        flash_mosi;
    logic        flash_miso = 1'b0;

    int total = 0;
    int bad   = 0;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .DESEL_CYC(DESEL_CYC)) dut (
        .clk28(clk28), .rst(rst), .read(read), .rden(rden), .addr(addr),
        .dataout(dataout), .data_valid(data_valid), .busy(busy),
        .flash_ncs(flash_ncs), .flash_sck(flash_sck), .flash_mosi(flash_mosi),
        .flash_miso(flash_miso)
    );

    // clock / reset
    always #5 clk28 = !clk28;

    // flash content
    logic [7:0] key;
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h013256) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ key;
    endfunction

    // behavioural flash: command/address on rising SCK, data out on falling SCK
    int          fm_bits = 0;
    int          fm_k;
    logic [31:0] fm_sh = '0;
    logic [23:0] fm_base = '0;
    logic [7:0]  fm_b;
    logic [31:0] cmd_q[$];

    always @(negedge flash_ncs) fm_bits = 0;

    always @(posedge flash_sck) begin
        if (!flash_ncs) begin
            if (fm_bits < 32) fm_sh = {fm_sh[30:0], flash_mosi};
            fm_bits++;
            if (fm_bits == 32) begin
                cmd_q.push_back(fm_sh);
                fm_base = fm_sh[23:0];
            end
        end
    end

    always @(negedge flash_sck) begin
        if (!flash_ncs && fm_bits >= 32) begin
            fm_k       = fm_bits - 32;
            fm_b       = mem_byte(fm_base + 24'(fm_k / 8));
            flash_miso = fm_b[7 - (fm_k % 8)];
        end
    end

    // bus monitors
    int   dv_count = 0;
    int   ncs_run = 0;
    int   last_run = 0;
    int   min_run = 1000000;
    int   cs_viol = 0;
    logic prev_ncs = 1'b1;
    logic mon_on = 1'b0;

    always @(negedge clk28) begin
        if (mon_on) begin
            if (data_valid) dv_count++;
            if (flash_ncs !== prev_ncs && flash_sck !== 1'b0) cs_viol++;
            if (flash_ncs) ncs_run++;
            else if (ncs_run > 0) begin
                last_run = ncs_run;
                if (ncs_run < min_run) min_run = ncs_run;
                ncs_run = 0;
            end
            prev_ncs = flash_ncs;
        end
    end

    // scoreboard / reference model state
    logic        link_open = 1'b0;
    logic [23:0] next_a = '0;
    int          exp_dv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [23:0] a);
        @(negedge clk28);
        read = 1'b1;
        addr = a;
        @(negedge clk28);
        read = 1'b0;
    endtask

    task automatic wait_dv(input int first, output int lat, output logic [7:0] d,
                           output logic bsy, output logic cs);
        lat = 0; d = '0; bsy = 1'b1; cs = 1'b1;
        for (int i = first; i <= 1000; i++) begin
            if (i > first) @(negedge clk28);
            if (data_valid) begin
                lat = i; d = dataout; bsy = busy; cs = flash_ncs;
                break;
            end
        end
    endtask

    task automatic check_read(input string tag, input logic [23:0] a, input int lat_exp,
                              input int ncmd, input logic cmd_exp, input int first);
        int         lat;
        logic [7:0] d;
        logic       bsy, cs;
        wait_dv(first, lat, d, bsy, cs);
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_data"}, d, mem_byte(a));
        chk({tag, "_busy_at_dv"}, bsy, 1'b0);
        chk({tag, "_ncs_at_dv"}, cs, 1'b0);
        chk({tag, "_cmd_count"}, cmd_q.size(), ncmd + int'(cmd_exp));
        if (cmd_exp && cmd_q.size() > 0) chk({tag, "_cmd_word"}, cmd_q[$], {8'h03, a});
        link_open = 1'b1;
        next_a    = a + 24'd1;
        exp_dv++;
    endtask

    task automatic do_read(input string tag, input logic [23:0] a);
        int   lat_exp;
        logic cmd_exp;
        int   ncmd;
        if (link_open && a == next_a) begin
            lat_exp = 1 + 8 * B;  cmd_exp = 1'b0;
        end else if (link_open) begin
            lat_exp = 1 + DESEL_CYC + 40 * B;  cmd_exp = 1'b1;
        end else begin
            lat_exp = 1 + 40 * B;  cmd_exp = 1'b1;
        end
        ncmd = cmd_q.size();
        issue(a);
        check_read(tag, a, lat_exp, ncmd, cmd_exp, 1);
    endtask

    initial begin
        int          ncmd;
        int          dv0;
        logic [23:0] ra;

        key = 8'($urandom);
        repeat (3) @(negedge clk28);
        mon_on = 1'b1;
        chk("rst_ncs", flash_ncs, 1'b1);
        chk("rst_sck", flash_sck, 1'b0);
        chk("rst_mosi", flash_mosi, 1'b0);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dataout", dataout, 8'h00);
        rst  = 1'b0;
        rden = 1'b1;
        repeat (2) @(negedge clk28);

        // cold read
        do_read("cold", 24'h013256);
        repeat (3) @(negedge clk28);
        chk("cold_ncs_held", flash_ncs, 1'b0);

        // sequential stream, each request two cycles after the previous strobe
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk28);
            do_read("seq", 24'h013256 + 24'(i));
        end

        // address wrap
        do_read("wrap_hi", 24'hFFFFFF);
        do_read("wrap_lo", 24'h000000);

        // non-sequential request from HOLD
        do_read("nonseq_a", 24'h000005);
        do_read("nonseq_b", 24'h000010);
        chk("nonseq_desel_len", last_run, DESEL_CYC);

        // close the stream and go cold again
        @(negedge clk28);
        rden = 1'b0;
        repeat (10) @(negedge clk28);
        chk("close_busy", busy, 1'b0);
        link_open = 1'b0;
        rden = 1'b1;

        // abort during ADDR bit 12
        dv0 = dv_count;
        issue(24'h000100);
        for (int i = 0; i < 400; i++) begin
            if (fm_bits >= 20) break;
            @(negedge clk28);
        end
        chk("abort_reach_addr12", fm_bits, 20);
        rden = 1'b0;
        @(negedge clk28);
        chk("abort_ncs", flash_ncs, 1'b1);
        chk("abort_sck", flash_sck, 1'b0);
        chk("abort_busy1", busy, 1'b1);
        repeat (3) @(negedge clk28);
        chk("abort_busy4", busy, 1'b1);
        @(negedge clk28);
        chk("abort_busy5", busy, 1'b0);
        repeat (5) @(negedge clk28);
        chk("abort_no_dv", dv_count, dv0);
        link_open = 1'b0;
        rden = 1'b1;

        // read pulse while busy is ignored
        ncmd = cmd_q.size();
        issue(24'h000200);
        repeat (4) @(negedge clk28);
        read = 1'b1;
        addr = 24'h000300;
        @(negedge clk28);
        read = 1'b0;
        check_read("busy_ignore", 24'h000200, 1 + 40 * B, ncmd, 1'b1, 6);
        repeat (20) @(negedge clk28);
        chk("busy_ignore_no_cmd", cmd_q.size(), ncmd + 1);

        // reset in the middle of DATA
        dv0 = dv_count;
        issue(24'h000201);
        repeat (10) @(negedge clk28);
        rst = 1'b1;
        @(negedge clk28);
        rst = 1'b0;
        chk("mid_rst_ncs", flash_ncs, 1'b1);
        chk("mid_rst_sck", flash_sck, 1'b0);
        chk("mid_rst_mosi", flash_mosi, 1'b0);
        chk("mid_rst_dv", data_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_dataout", dataout, 8'h00);
        repeat (40) @(negedge clk28);
        chk("mid_rst_no_dv", dv_count, dv0);
        link_open = 1'b0;

        // randomized mix of sequential and jump requests
        for (int i = 0; i < 10; i++) begin
            ra = ($urandom_range(0, 1) == 1 && link_open) ? next_a : 24'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk28);
            do_read("rand", ra);
        end

        repeat (10) @(negedge clk28);
        chk("dv_total", dv_count, exp_dv);
        chk("ncs_while_sck_low", cs_viol, 0);
        chk("desel_min_ok", min_run >= DESEL_CYC, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
